// File: rtl/fsm_input_conditioner_pkg.sv
// Shared types and constants for the switch-controlled FSM input front-end.
package fsm_io_pkg;

  // Debounce state of the push-button.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // Defaults sized for a board clock in the tens of MHz.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_NUM_SW          = 5;

  // Slide-switch roles as seen by the downstream FSM.
  localparam int unsigned SW_RESET = 0;  // synchronous return-to-state-0
  localparam int unsigned SW_1     = 1;
  localparam int unsigned SW_2     = 2;
  localparam int unsigned SW_3     = 3;
  localparam int unsigned SW_4     = 4;

  // Converts a raw key level into 1 = pressed.
  function automatic logic key_pressed(input logic raw, input bit active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/fsm_input_conditioner_debounce_bit.sv
// One slide switch: two-flop synchroniser followed by a stable-sample counter.
// The clean level only updates after DEBOUNCE_CYCLES consecutive samples that
// disagree with it; any agreeing sample restarts the count.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_clean,
  output logic o_changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_clean;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous switch level into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // Count disagreeing samples; accept the new level at the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_clean   <= 1'b0;
      r_changed <= 1'b0;
    end else if (r_sync != r_clean) begin
      if (r_cnt == CNT_TERM) begin
        r_clean   <= r_sync;
        r_cnt     <= '0;
        r_changed <= 1'b1;
      end else begin
        r_cnt     <= r_cnt + 1'b1;
        r_changed <= 1'b0;
      end
    end else begin
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end
  end

  assign o_clean   = r_clean;
  assign o_changed = r_changed;

endmodule

// File: rtl/fsm_input_conditioner.sv
// Input conditioner for the five-state FSM: synchronises and debounces the
// push-button into a single-cycle step pulse plus a held level, and debounces
// the slide switches into clean levels with per-bit change pulses.
module fsm_input_conditioner
  import fsm_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned NUM_SW          = DEF_NUM_SW,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_raw,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic              step,
  output logic              key_held,
  output logic [NUM_SW-1:0] sw_clean,
  output logic [NUM_SW-1:0] sw_changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic KEY_RELEASED_RAW = KEY_ACTIVE_LOW;

  logic             r_key_meta;
  logic             r_key_sync;
  logic             w_key_s;

  key_state_e       r_state;
  key_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_step;
  logic             w_step_nxt;
  logic             r_held;
  logic             w_held_nxt;

  logic [NUM_SW-1:0] w_sw_clean;
  logic [NUM_SW-1:0] w_sw_changed;

  // Key synchroniser; resets to the released level so no false press appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_meta <= KEY_RELEASED_RAW;
      r_key_sync <= KEY_RELEASED_RAW;
    end else begin
      r_key_meta <= key_raw;
      r_key_sync <= r_key_meta;
    end
  end

  assign w_key_s = key_pressed(r_key_sync, KEY_ACTIVE_LOW);

  // Key FSM state, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_held  <= w_held_nxt;
    end
  end

  // Key FSM next-state logic; step fires only on the PRESS_WAIT -> HELD edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    w_held_nxt  = r_held;
    unique case (r_state)
      IDLE: begin
        if (w_key_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_key_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_TERM) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_step_nxt  = 1'b1;
          w_held_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_key_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_key_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_TERM) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_held_nxt  = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_held_nxt  = 1'b0;
      end
    endcase
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (sw_raw[g]),
      .o_clean  (w_sw_clean[g]),
      .o_changed(w_sw_changed[g])
    );
  end

  assign step       = r_step;
  assign key_held   = r_held;
  assign sw_clean   = w_sw_clean;
  assign sw_changed = w_sw_changed;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Directed bench for fsm_input_conditioner with DEBOUNCE_CYCLES=8.
// Inputs change 1 ns after a rising edge (call that edge e0); outputs are
// sampled 1 ns after each following edge, so sample k reflects edge ek.
module tb_fsm_input_conditioner;

  localparam int unsigned DC = 8;
  localparam int unsigned NSW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           key_raw;
  logic [NSW-1:0] sw_raw;
  logic           step;
  logic           key_held;
  logic [NSW-1:0] sw_clean;
  logic [NSW-1:0] sw_changed;

  int checks = 0;
  int errors = 0;
  int steps_seen;

  fsm_input_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .NUM_SW         (NSW),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .sw_raw    (sw_raw),
    .step      (step),
    .key_held  (key_held),
    .sw_clean  (sw_clean),
    .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_step, input logic e_held,
                         input logic [NSW-1:0] e_clean, input logic [NSW-1:0] e_chg);
    chk({tag, ".step"}, 32'(step), 32'(e_step));
    chk({tag, ".key_held"}, 32'(key_held), 32'(e_held));
    chk({tag, ".sw_clean"}, 32'(sw_clean), 32'(e_clean));
    chk({tag, ".sw_changed"}, 32'(sw_changed), 32'(e_chg));
    if (step === 1'b1) steps_seen++;
  endtask

  initial begin
    // 1. Reset then idle.
    rst = 1'b1; key_raw = 1'b1; sw_raw = '0;
    steps_seen = 0;
    repeat (3) tick();
    chk_all("reset", 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk_all("idle", 1'b0, 1'b0, '0, '0);
    end

    // 2. Clean press: step after e10 only, held from e10.
    steps_seen = 0;
    key_raw = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk_all("press", k == 10, k >= 10, '0, '0);
    end
    chk("press.step_count", 32'(steps_seen), 32'd1);
    key_raw = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk_all("release", 1'b0, k < 10, '0, '0);
    end

    // 3. Bouncy press: 7 toggles every 3 cycles, last one (t=18) leaves key pressed.
    steps_seen = 0;
    for (int t = 0; t <= 33; t++) begin
      if (t < 20 && (t % 3) == 0) key_raw = ~key_raw;
      tick();
      chk_all("bounce", t == 27, t >= 27, '0, '0);
    end
    chk("bounce.step_count", 32'(steps_seen), 32'd1);
    key_raw = 1'b1;
    repeat (14) tick();
    chk_all("bounce_rel", 1'b0, 1'b0, '0, '0);

    // 4. Switch glitch rejected, then a stable switch accepted.
    sw_raw = 5'b00100;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("sw_glitch", 1'b0, 1'b0, '0, '0);
    end
    sw_raw = '0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk_all("sw_glitch_after", 1'b0, 1'b0, '0, '0);
    end
    sw_raw = 5'b00100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_all("sw_on", 1'b0, 1'b0, (k >= 10) ? 5'b00100 : 5'b00000,
              (k == 10) ? 5'b00100 : 5'b00000);
    end
    sw_raw = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk_all("sw_off", 1'b0, 1'b0, (k < 10) ? 5'b00100 : 5'b00000,
              (k == 10) ? 5'b00100 : 5'b00000);
    end

    // 5. Switch and key launched together land together.
    steps_seen = 0;
    sw_raw = 5'b00100; key_raw = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk_all("simul", k == 10, k >= 10, (k >= 10) ? 5'b00100 : 5'b00000,
              (k == 10) ? 5'b00100 : 5'b00000);
    end
    chk("simul.step_count", 32'(steps_seen), 32'd1);
    sw_raw = '0; key_raw = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk_all("simul_rel", 1'b0, k < 10, (k < 10) ? 5'b00100 : 5'b00000,
              (k == 10) ? 5'b00100 : 5'b00000);
    end

    // 6. Reset in the middle of PRESS_WAIT with key kept pressed.
    steps_seen = 0;
    key_raw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_all("pre_rst", 1'b0, 1'b0, '0, '0);
    end
    rst = 1'b1;
    #1;
    chk_all("rst_async", 1'b0, 1'b0, '0, '0);
    tick();
    chk_all("rst_hold1", 1'b0, 1'b0, '0, '0);
    tick();
    chk_all("rst_hold2", 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk_all("post_rst", k == 10, k >= 10, '0, '0);
    end
    chk("post_rst.step_count", 32'(steps_seen), 32'd1);
    key_raw = 1'b1;
    repeat (14) tick();
    chk_all("final", 1'b0, 1'b0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
